// File: rtl/dds_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dds_pkg : shared widths, DAC command codes, FSM states, sample conversion |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package dds_pkg;

  localparam int SAMPLE_W = 17;
  localparam int DAC_W    = 16;
  localparam int FRAME_W  = 24;

  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CS_HOLD = 2'd2
  } state_t;

  // Flipping the sign bit biases the range to unsigned; the shift drops the LSB.
  function automatic logic [DAC_W-1:0] to_offset_bin(input logic signed [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] w_biased;
    w_biased = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    return DAC_W'(w_biased >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_clk_gen : CPOL=0 SCLK generator with rise and fall (shift) strobes   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module spi_clk_gen #(
  parameter  int SCLK_DIV = 4,
  localparam int PHASE_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  output logic               o_sclk,
  output logic               o_rise,
  output logic               o_fall,
  output logic [PHASE_W-1:0] o_phase
);

  localparam logic [PHASE_W-1:0] c_PHASE_LAST = PHASE_W'(SCLK_DIV - 1);

  logic [PHASE_W-1:0] r_phase;
  logic               r_sclk;
  logic               w_phase_end;

  assign w_phase_end = i_enable && (r_phase == c_PHASE_LAST);

  // Disabling parks SCLK low with a fresh phase so the next frame starts aligned.
  always_ff @(posedge clk) begin
    if (reset || !i_enable) begin
      r_phase <= '0;
      r_sclk  <= 1'b0;
    end else if (r_phase == c_PHASE_LAST) begin
      r_phase <= '0;
      r_sclk  <= ~r_sclk;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  assign o_sclk  = r_sclk;
  assign o_rise  = w_phase_end && !r_sclk;
  assign o_fall  = w_phase_end && r_sclk;
  assign o_phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/dac_spi_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dac_spi_serializer : signed sample -> offset-binary 24-bit SPI DAC frame |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dac_spi_serializer
  import dds_pkg::*;
#(
  parameter int         SCLK_DIV = 4,
  parameter int         CS_IDLE  = 2,
  parameter logic [3:0] DAC_CMD  = CMD_WRITE_UPDATE,
  parameter logic [3:0] DAC_ADDR = 4'b0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       dac_cs_n,
  output logic                       dac_sclk,
  output logic                       dac_mosi,
  output logic                       frame_done,
  output logic [15:0]                drop_count
);

  localparam int PHASE_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int IDLE_W  = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam logic [IDLE_W-1:0]  c_IDLE_LAST = IDLE_W'(CS_IDLE - 1);
  localparam logic [4:0]         c_LAST_BIT  = 5'(FRAME_W - 1);
  localparam logic [PHASE_W-1:0] c_PHASE_END = PHASE_W'(SCLK_DIV - 1);

  state_t                      r_state;
  state_t                      w_next_state;
  logic                        r_hold_full;
  logic signed [SAMPLE_W-1:0]  r_hold_data;
  logic [FRAME_W-1:0]          r_shreg;
  logic [4:0]                  r_bit_cnt;
  logic [IDLE_W-1:0]           r_idle_cnt;
  logic                        r_frame_done;
  logic [15:0]                 r_drop_cnt;

  logic                        w_cs_n;
  logic                        w_mosi;
  logic                        w_sclk_en;
  logic                        w_sclk;
  logic                        w_rise;
  logic                        w_fall;
  logic [PHASE_W-1:0]          w_phase;
  logic                        w_accept;
  logic                        w_load;
  logic                        w_last_bit;

  spi_clk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_spi_clk_gen (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_sclk_en),
    .o_sclk   (w_sclk),
    .o_rise   (w_rise),
    .o_fall   (w_fall),
    .o_phase  (w_phase)
  );

  assign w_accept   = sample_valid && !r_hold_full;
  assign w_load     = (r_state == IDLE) && r_hold_full;
  assign w_last_bit = w_fall && (r_bit_cnt == c_LAST_BIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (r_hold_full) w_next_state = SHIFT;
      SHIFT:   if (w_last_bit) w_next_state = CS_HOLD;
      CS_HOLD: if (r_idle_cnt == c_IDLE_LAST) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_cs_n    = 1'b1;
    w_mosi    = 1'b0;
    w_sclk_en = 1'b0;
    case (r_state)
      SHIFT: begin
        w_cs_n    = 1'b0;
        w_mosi    = r_shreg[FRAME_W-1];
        w_sclk_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Holding register: accept and load never coincide since ready is low while full.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= sample_in;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_shreg   <= {DAC_CMD, DAC_ADDR, to_offset_bin(r_hold_data)};
      r_bit_cnt <= '0;
    end else if ((r_state == SHIFT) && w_fall) begin
      r_shreg   <= {r_shreg[FRAME_W-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state != CS_HOLD)) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_frame_done <= w_last_bit;
      if (sample_valid && r_hold_full && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  a_strobe_phase: assert property (@(posedge clk) disable iff (reset)
    (w_rise || w_fall) |-> (w_phase == c_PHASE_END));

  assign sample_ready = !r_hold_full;
  assign dac_cs_n     = w_cs_n;
  assign dac_sclk     = w_sclk;
  assign dac_mosi     = w_mosi;
  assign frame_done   = r_frame_done;
  assign drop_count   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dac_spi_serializer : randomized bench with a frame-level reference    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dac_spi_serializer;

  localparam int SCLK_DIV = 4;
  localparam int CS_IDLE  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_mosi;
  logic        frame_done;
  logic [15:0] drop_count;

  dac_spi_serializer #(
    .SCLK_DIV (SCLK_DIV),
    .CS_IDLE  (CS_IDLE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_cs_n     (dac_cs_n),
    .dac_sclk     (dac_sclk),
    .dac_mosi     (dac_mosi),
    .frame_done   (frame_done),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: command 3, address 0, code = (sample + 65536) / 2.
  function automatic int exp_frame(input int s);
    return (3 << 20) | ((s + 65536) / 2);
  endfunction

  function automatic int rand_sample();
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  // Monitor / reference model state
  int   exp_q[$];
  logic prev_csn = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int   cs_low_len = 0, hi_len = 0, sclk_hi = 0, nbits = 0;
  logic [23:0] bits = '0;
  int   last_frame = 0, frames_ended = 0, done_pulses = 0;
  int   drop_model = 0;
  int   cyc = 0, acc_n = 0;
  int   acc_time[2];
  logic in_frame = 1'b0;
  logic gap_on = 1'b0, acc_arm = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      prev_csn = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0;
      nbits = 0; cs_low_len = 0; hi_len = 0; sclk_hi = 0;
      drop_model = 0; in_frame = 1'b0;
    end else begin
      if (frame_done) done_pulses++;
      if (!acc_arm) acc_n = 0;
      if (sample_valid && sample_ready) begin
        exp_q.push_back(exp_frame(int'($signed(sample_in))));
        if (acc_arm && acc_n < 2) begin
          acc_time[acc_n] = cyc;
          acc_n++;
        end
      end
      if (sample_valid && !sample_ready && drop_model < 65535) drop_model++;

      if (prev_csn && !dac_cs_n) begin
        if (gap_on) check_eq("cs_gap", hi_len, CS_IDLE + 1);
        cs_low_len = 0; nbits = 0; bits = '0; in_frame = 1'b1;
      end
      if (!dac_cs_n) cs_low_len++;
      else hi_len++;

      if (!prev_sclk && dac_sclk) begin
        if (nbits == 0) check_eq("first_rise", cs_low_len, SCLK_DIV + 1);
        check_eq("mosi_stable", dac_mosi, prev_mosi);
        bits = {bits[22:0], dac_mosi};
        nbits++;
        sclk_hi = 0;
      end
      if (dac_sclk) sclk_hi++;
      if (prev_sclk && !dac_sclk) check_eq("sclk_high", sclk_hi, SCLK_DIV);

      if (!prev_csn && dac_cs_n && in_frame) begin
        check_eq("cs_low_len", cs_low_len, 48 * SCLK_DIV);
        check_eq("nbits", nbits, 24);
        check_eq("frame_done", frame_done, 1);
        check_eq("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("frame_data", bits, exp_q.pop_front());
        last_frame = int'(bits);
        frames_ended++;
        in_frame = 1'b0;
        hi_len = 1;
      end

      prev_csn  = dac_cs_n;
      prev_sclk = dac_sclk;
      prev_mosi = dac_mosi;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    int t = 0;
    while (!sample_ready && t < 1000) begin
      tick();
      t++;
    end
    check_eq("ready_wait", sample_ready, 1);
    sample_valid = 1'b1;
    sample_in    = 17'(s);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || !sample_ready || !dac_cs_n) && t < 5000) begin
      tick();
      t++;
    end
    repeat (4) tick();
    check_eq("drain", exp_q.size(), 0);
  endtask

  int dir_s[4] = '{-65536, 65535, 0, -1};
  int dir_f[4] = '{32'h300000, 32'h30FFFF, 32'h308000, 32'h307FFF};

  initial begin
    int d0, f0, bad, t;
    reset = 1'b1; sample_valid = 1'b0; sample_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cs_n", dac_cs_n, 1);
    check_eq("rst_sclk", dac_sclk, 0);
    check_eq("rst_mosi", dac_mosi, 0);
    check_eq("rst_ready", sample_ready, 1);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_drop", drop_count, 0);
    tick();
    reset = 1'b0;
    tick();

    // Conversion corners
    d0 = done_pulses;
    for (int i = 0; i < 4; i++) begin
      send(dir_s[i]);
      wait_drain();
      check_eq("conv", last_frame, dir_f[i]);
    end
    check_eq("done_pulses4", done_pulses - d0, 4);

    // Random single frames
    for (int i = 0; i < 6; i++) begin
      send(rand_sample());
      wait_drain();
    end

    // Drops while hold is full behind a shifting frame
    send(rand_sample());
    send(rand_sample());
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample_in    = 17'(rand_sample());
      tick();
    end
    sample_valid = 1'b0;
    @(negedge clk);
    check_eq("drop10", drop_count, 10);
    check_eq("drop10_model", drop_count, drop_model);
    tick();
    wait_drain();

    // Back-to-back stream, also drives drop_count into saturation
    acc_arm = 1'b1;
    sample_valid = 1'b1;
    for (int i = 0; i < 70200; i++) begin
      sample_in = 17'(rand_sample());
      tick();
      if (i == 5) check_eq("acc_spacing", acc_time[1] - acc_time[0], 2);
      if (i == 300) gap_on = 1'b1;
    end
    gap_on = 1'b0;
    sample_valid = 1'b0;
    acc_arm = 1'b0;
    @(negedge clk);
    check_eq("drop_sat", drop_count, 16'hFFFF);
    check_eq("drop_sat_model", drop_count, drop_model);
    tick();
    sample_valid = 1'b1;
    repeat (5) tick();
    sample_valid = 1'b0;
    @(negedge clk);
    check_eq("drop_sat_hold", drop_count, 16'hFFFF);
    tick();
    wait_drain();

    // Reset in the middle of a frame
    send(rand_sample());
    t = 0;
    while (nbits < 10 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_eq("reach_rise10", nbits >= 10, 1);
    d0 = done_pulses;
    f0 = frames_ended;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_cs_n", dac_cs_n, 1);
    check_eq("mid_rst_sclk", dac_sclk, 0);
    check_eq("mid_rst_mosi", dac_mosi, 0);
    check_eq("mid_rst_ready", sample_ready, 1);
    check_eq("mid_rst_drop", drop_count, 0);
    check_eq("mid_rst_done", frame_done, 0);
    tick();
    check_eq("mid_rst_no_pulse", done_pulses - d0, 0);
    send(rand_sample());
    wait_drain();
    check_eq("post_rst_frames", frames_ended - f0, 1);

    // Idle stability
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (dac_cs_n !== 1'b1 || dac_sclk !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check_eq("idle_stable", bad, 0);
    check_eq("done_vs_frames", done_pulses, frames_ended);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_spi_serializer.md
Name: dac_spi_serializer

Overview:
- Downstream stage of the DDS waveform generators: takes one signed 17-bit sample (range -65536..65535) per handshake.
- Converts the sample to 16-bit offset-binary and ships it to an external 16-bit SPI DAC as a 24-bit frame.
- Frame layout: 4-bit command, 4-bit address, 16-bit code, MSB first.
- Has a one-entry holding register, so the next sample is accepted while the current frame shifts. Counts samples lost when the producer (no backpressure) presents data while the block is full.

Parameters:
- SCLK_DIV, 4: clk cycles per SCLK half-period; legal range >= 1.
- CS_IDLE, 2: clk cycles cs_n is held high after each frame; legal range >= 1.
- DAC_CMD, 4'b0011: command nibble (write and update).
- DAC_ADDR, 4'b0000: DAC channel address nibble.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sample_in  in  17  signed sample, two's complement.
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  holding register empty; the sample is accepted when valid && ready at the clk edge.
- dac_cs_n  out  1  SPI chip select, active low.
- dac_sclk  out  1  SPI clock, CPOL=0.
- dac_mosi  out  1  SPI data; changes on SCLK falling edges, stable at rising edges.
- frame_done  out  1  one-cycle pulse when the last bit of a frame completes.
- drop_count  out  16  saturating count of cycles with valid && !ready.

Behaviour:
- Interface decision: one clock, clk. reset is synchronous and active-high; all state is sampled on the clk rising edge.
- Reset values:
  - sample_ready=1, dac_cs_n=1, dac_sclk=0, dac_mosi=0, frame_done=0, drop_count=0.
  - Holding register emptied; FSM in IDLE.
- Reset mid-frame: the partial frame is abandoned. cs_n returns high on the first cycle after the reset edge, and no frame_done pulse is generated.
- Conversion: code[15:0] = {~s[16], s[15:1]}, i.e. the LSB is dropped and the sign bit inverted.
  - -65536 -> 0x0000, 65535 -> 0xFFFF, 0 -> 0x8000, -1 -> 0x7FFF.
  - No clamping is needed. Conversion is applied when the frame is loaded.
- Frame = {DAC_CMD, DAC_ADDR, code}, 24 bits.
- sample_ready = !hold_full, registered. Accept sets hold_full and captures sample_in.
- FSM states:
  - IDLE: cs_n=1, sclk=0. If hold_full: load the shift register with the frame, clear hold_full, go to SHIFT. If hold is empty, stay in IDLE.
  - SHIFT: cs_n=0 and mosi = shreg[23].
    - Each bit is SCLK_DIV cycles with sclk low, then SCLK_DIV cycles with sclk high.
    - At the end of the high phase, sclk returns low, shreg shifts left and bit_cnt increments.
    - After bit 24's high phase: frame_done=1 for that one cycle, go to CS_HOLD.
  - CS_HOLD: cs_n=1, sclk=0, mosi=0 for CS_IDLE cycles, then go to IDLE.
- Latency and timing:
  - Accept at edge T; load at edge T+1; cs_n low from T+1.
  - First SCLK rise at T+1+SCLK_DIV.
  - cs_n low for exactly 48*SCLK_DIV cycles.
  - cs_n high between back-to-back frames for exactly CS_IDLE+1 cycles.
- Buffering: after the load, ready is high again one cycle later, so a new sample can be taken mid-frame. It waits in hold until IDLE.
- Simultaneous events: accept and load can never coincide, because ready=0 whenever hold_full=1.
- drop_count: increments once per cycle with sample_valid && !sample_ready, and saturates at 0xFFFF (no wrap). Dropped samples are not stored.
- bit_cnt is 5 bits and terminates at 24; the phase counter width is $clog2(SCLK_DIV).

Decomposition:
- Package dds_pkg holds:
  - SAMPLE_W=17, DAC_W=16, FRAME_W=24.
  - DAC command constants (CMD_WRITE_UPDATE=4'b0011).
  - FSM state enum {IDLE, SHIFT, CS_HOLD}.
  - Function to_offset_bin(sample) implementing the conversion.
- One sub-module: spi_clk_gen. Takes clk, reset, enable; produces sclk, a rise strobe, a fall/shift strobe, and the SCLK_DIV phase counter.
- The FSM, holding register and drop counter stay in the top module.

Test Plan:
- Conversion and framing: accept -65536, then 65535, then 0, then -1 (defaults). Bits captured on the 24 SCLK rises must equal 0x300000, 0x30FFFF, 0x308000, 0x307FFF respectively, with 4 frame_done pulses.
- Timing (SCLK_DIV=4, CS_IDLE=2): single sample accepted at edge T.
  - cs_n falls at T+1 and stays low 192 cycles.
  - First sclk rise at T+5; 24 rises, each sclk high phase 4 cycles.
  - mosi is stable across each rise.
- Back-to-back: hold sample_valid high with a new value every accept.
  - Second accept occurs 2 cycles after the first.
  - Frames are contiguous with a cs_n high gap of exactly 3 cycles.
  - Frame data matches each accepted sample in order.
- Drops: while one frame is shifting and hold is full, assert valid for 10 cycles -> drop_count=10. Force 70000 drop cycles -> drop_count=0xFFFF and stays there.
- Reset mid-frame: assert reset for 1 cycle after the 10th SCLK rise.
  - Next cycle: cs_n=1, sclk=0, mosi=0, ready=1, drop_count=0, and no frame_done.
  - A subsequent sample then produces a complete, correct 24-bit frame.
- Idle stability: no sample_valid for 500 cycles -> cs_n=1, sclk=0, frame_done=0 throughout.
